// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment codes (bit6=a .. bit0=g),
// capture FSM state encoding, decoded digit record and the select-to-slot helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_COUNT  = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] value;
        logic       blank;
        logic       err;
    } digit_t;

    // Maps a single-low digit select to its slot; callers qualify validity separately.
    function automatic logic [1:0] slot_of(input logic [3:0] an);
        case (an)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_capture_if.sv
// Display-side bus of the capture block: raw segment/select drive in,
// recovered frame out on a valid/ready handshake.
interface seg7_capture_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [3:0]  out_blank;
    logic [3:0]  out_err;
    logic        overrun;

    modport master (
        output seg, an, out_ready,
        input  out_valid, out_bcd, out_blank, out_err, overrun
    );

    modport slave (
        input  seg, an, out_ready,
        output out_valid, out_bcd, out_blank, out_err, overrun
    );
endinterface

// File: rtl/seg7_to_bcd.sv
// Inverse seven-segment decoder: active-low pattern to BCD value with
// blank (all segments off) and err (pattern not in the table) flags.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output digit_t     dig
);

    always_comb begin
        dig = '{value: 4'd0, blank: 1'b0, err: 1'b0};
        case (seg)
            SEG_0:     dig.value = 4'd0;
            SEG_1:     dig.value = 4'd1;
            SEG_2:     dig.value = 4'd2;
            SEG_3:     dig.value = 4'd3;
            SEG_4:     dig.value = 4'd4;
            SEG_5:     dig.value = 4'd5;
            SEG_6:     dig.value = 4'd6;
            SEG_7:     dig.value = 4'd7;
            SEG_8:     dig.value = 4'd8;
            SEG_9:     dig.value = 4'd9;
            SEG_BLANK: dig.blank = 1'b1;
            default:   dig.err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Recovers the value shown on a multiplexed active-low 4-digit display:
// debounces each select dwell, fills four digit slots and emits whole frames.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic           clk,
    input  logic           rst,
    seg7_capture_if.slave  bus
);

    localparam logic [1:0] S_SEARCH = 2'(ST_SEARCH);
    localparam logic [1:0] S_COUNT  = 2'(ST_COUNT);
    localparam logic [1:0] S_HOLD   = 2'(ST_HOLD);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic [3:0]       mask_q;
    digit_t           slots [4];
    digit_t           dig;

    logic       an_ok, same_an, same_in, restart, capture, frame_done;
    logic [1:0] idx;

    logic [15:0] frame_bcd;
    logic [3:0]  frame_blank, frame_err;

    logic        vld_p0, ovr_p0;
    logic [15:0] bcd_p0;
    logic [3:0]  blank_p0, err_p0;

    seg7_to_bcd u_dec (
        .seg (bus.seg),
        .dig (dig)
    );

    // Any break in the dwell restarts it on the current cycle, so a new dwell
    // that begins right after a select change still counts its first cycle.
    always_comb begin
        an_ok   = $onehot(~bus.an);
        same_an = (bus.an == an_q);
        same_in = same_an && (bus.seg == seg_q);
        cnt_inc = cnt + CNT_W'(1);
        restart = (state == S_SEARCH) ||
                  (state == S_COUNT && !same_in) ||
                  (state == S_HOLD  && !same_an);
        capture = 1'b0;
        if (restart)
            capture = an_ok && (STABLE_CYCLES == 1);
        else if (state == S_COUNT)
            capture = (cnt_inc == CNT_W'(STABLE_CYCLES));
        idx        = slot_of(bus.an);
        frame_done = (mask_q == 4'hF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_SEARCH;
            cnt   <= '0;
        end else if (restart) begin
            if (an_ok) begin
                state <= capture ? S_HOLD : S_COUNT;
                cnt   <= CNT_W'(1);
            end else begin
                state <= S_SEARCH;
                cnt   <= '0;
            end
        end else if (state == S_COUNT) begin
            cnt <= cnt_inc;
            if (capture)
                state <= S_HOLD;
        end else if (state != S_HOLD) begin
            state <= S_SEARCH;
        end
    end

    always_ff @(posedge clk) begin
        if (restart && an_ok) begin
            an_q  <= bus.an;
            seg_q <= bus.seg;
        end
        if (capture)
            slots[idx] <= dig;
    end

    always_comb begin
        frame_bcd   = '0;
        frame_blank = '0;
        frame_err   = '0;
        for (int i = 0; i < 4; i++) begin
            frame_bcd[i*4 +: 4] = slots[i].value;
            frame_blank[i]      = slots[i].blank;
            frame_err[i]        = slots[i].err;
        end
    end

    // ---- output stage: frame register and valid/ready handshake ----
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q   <= 4'h0;
            vld_p0   <= 1'b0;
            ovr_p0   <= 1'b0;
            bcd_p0   <= '0;
            blank_p0 <= '0;
            err_p0   <= '0;
        end else begin
            ovr_p0 <= 1'b0;
            mask_q <= (frame_done ? 4'h0 : mask_q) | (capture ? (4'b0001 << idx) : 4'h0);
            if (frame_done && (!vld_p0 || bus.out_ready)) begin
                vld_p0   <= 1'b1;
                bcd_p0   <= frame_bcd;
                blank_p0 <= frame_blank;
                err_p0   <= frame_err;
            end else if (frame_done) begin
                ovr_p0 <= 1'b1;
            end else if (vld_p0 && bus.out_ready) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign bus.out_valid = vld_p0;
    assign bus.out_bcd   = bcd_p0;
    assign bus.out_blank = blank_p0;
    assign bus.out_err   = err_p0;
    assign bus.overrun   = ovr_p0;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a dwell/frame model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_seg7_capture;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en   = 1'b0;

    always #5 clk = ~clk;

    seg7_capture_if bus ();

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] codes [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAD   = 7'b1111110;
    localparam logic [3:0] IDLE  = 4'b1111;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         run;
    logic [3:0] p_an;
    logic [6:0] p_seg;
    bit         held;
    logic [3:0] m_mask;
    logic [3:0] m_val [4];
    logic       m_blank [4];
    logic       m_err [4];
    logic        e_valid, e_ovr;
    logic [15:0] e_bcd;
    logic [3:0]  e_blank, e_err;

    always @(posedge clk) begin
        if (rst) begin
            run = 0; p_an = IDLE; p_seg = BLANK; held = 0; m_mask = 4'h0;
            e_valid = 0; e_ovr = 0; e_bcd = 0; e_blank = 0; e_err = 0;
        end else begin
            e_ovr = 0;
            if (m_mask == 4'hF) begin
                if (!e_valid || bus.out_ready) begin
                    e_valid = 1;
                    for (int i = 0; i < 4; i++) begin
                        e_bcd[i*4 +: 4] = m_val[i];
                        e_blank[i]      = m_blank[i];
                        e_err[i]        = m_err[i];
                    end
                end else begin
                    e_ovr = 1;
                end
                m_mask = 4'h0;
            end else if (e_valid && bus.out_ready) begin
                e_valid = 0;
            end
            if (bus.an != p_an) held = 0;
            if (bus.an == p_an && bus.seg == p_seg) run++;
            else run = 1;
            p_an  = bus.an;
            p_seg = bus.seg;
            if ($countones(~bus.an) == 1 && !held && run == S) begin
                for (int k = 0; k < 4; k++) begin
                    if (!bus.an[k]) begin
                        m_val[k] = 4'd0; m_blank[k] = 0; m_err[k] = 1;
                        if (bus.seg == BLANK) begin m_blank[k] = 1; m_err[k] = 0; end
                        for (int d = 0; d < 10; d++)
                            if (bus.seg == codes[d]) begin m_val[k] = 4'(d); m_err[k] = 0; end
                        m_mask[k] = 1'b1;
                    end
                end
                held = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("cyc_valid",   32'(bus.out_valid), 32'(e_valid));
            check("cyc_bcd",     32'(bus.out_bcd),   32'(e_bcd));
            check("cyc_blank",   32'(bus.out_blank), 32'(e_blank));
            check("cyc_err",     32'(bus.out_err),   32'(e_err));
            check("cyc_overrun", 32'(bus.overrun),   32'(e_ovr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        dwell(4'b1110, s0, S);
        dwell(4'b1101, s1, S);
        dwell(4'b1011, s2, S);
        dwell(4'b0111, s3, S);
    endtask

    initial begin
        rst = 1'b1;
        bus.an = IDLE;
        bus.seg = BLANK;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_bcd", 32'(bus.out_bcd), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        rst = 1'b0;

        // Basic frame "1234"
        frame(codes[4], codes[3], codes[2], codes[1]);
        dwell(IDLE, BLANK, 1);
        check("t1_valid", 32'(bus.out_valid), 1);
        check("t1_bcd", 32'(bus.out_bcd), 32'h1234);
        check("t1_blank", 32'(bus.out_blank), 0);
        check("t1_err", 32'(bus.out_err), 0);
        dwell(IDLE, BLANK, 1);
        check("t1_drop", 32'(bus.out_valid), 0);

        // Short dwell on slot 0 is ignored; blank digit later fills it
        dwell(4'b1110, codes[7], S - 1);
        dwell(IDLE, BLANK, 1);
        dwell(4'b1101, codes[9], S);
        dwell(4'b1011, codes[8], S);
        dwell(4'b0111, codes[6], S);
        dwell(IDLE, BLANK, 2);
        check("t2_noframe", 32'(bus.out_valid), 0);
        dwell(4'b1110, BLANK, S);
        dwell(IDLE, BLANK, 1);
        check("t2_valid", 32'(bus.out_valid), 1);
        check("t2_bcd", 32'(bus.out_bcd), 32'h6890);
        check("t2_blank", 32'(bus.out_blank), 32'h1);
        dwell(IDLE, BLANK, 1);

        // Illegal pattern on slot 1
        frame(codes[3], BAD, codes[0], codes[5]);
        dwell(IDLE, BLANK, 1);
        check("t3_bcd", 32'(bus.out_bcd), 32'h5003);
        check("t3_err", 32'(bus.out_err), 32'h2);
        check("t3_blank", 32'(bus.out_blank), 0);
        dwell(IDLE, BLANK, 1);

        // Back-pressure: second frame dropped with overrun
        bus.out_ready = 1'b0;
        frame(codes[1], codes[2], codes[3], codes[4]);
        dwell(IDLE, BLANK, 1);
        check("t4_valid", 32'(bus.out_valid), 1);
        check("t4_bcd", 32'(bus.out_bcd), 32'h4321);
        frame(codes[5], codes[6], codes[7], codes[8]);
        dwell(IDLE, BLANK, 1);
        check("t4_overrun", 32'(bus.overrun), 1);
        check("t4_hold_bcd", 32'(bus.out_bcd), 32'h4321);
        dwell(IDLE, BLANK, 1);
        check("t4_ovr_pulse", 32'(bus.overrun), 0);
        check("t4_still_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        dwell(IDLE, BLANK, 1);
        check("t4_drop", 32'(bus.out_valid), 0);

        // Glitched seg and double select never capture
        dwell(4'b1110, codes[2], 2);
        dwell(4'b1110, codes[3], 1);
        dwell(4'b1110, codes[2], 2);
        dwell(4'b1100, codes[3], 6);
        dwell(4'b1101, codes[1], S);
        dwell(4'b1011, codes[1], S);
        dwell(4'b0111, codes[1], S);
        dwell(IDLE, BLANK, 2);
        check("t5_noframe", 32'(bus.out_valid), 0);
        dwell(4'b1110, codes[9], S);
        dwell(IDLE, BLANK, 1);
        check("t5_bcd", 32'(bus.out_bcd), 32'h1119);
        dwell(IDLE, BLANK, 1);

        // Reset mid-frame discards the partial mask
        dwell(4'b1110, codes[1], S);
        dwell(4'b1101, codes[2], S);
        rst = 1'b1;
        dwell(IDLE, BLANK, 2);
        rst = 1'b0;
        dwell(4'b1101, codes[2], S);
        dwell(4'b1011, codes[3], S);
        dwell(4'b0111, codes[4], S);
        dwell(IDLE, BLANK, 3);
        check("t5_rst_noframe", 32'(bus.out_valid), 0);

        // Completion coincides with transfer
        rst = 1'b1;
        dwell(IDLE, BLANK, 1);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        frame(codes[2], codes[4], codes[6], codes[8]);
        dwell(IDLE, BLANK, 1);
        check("t6_first", 32'(bus.out_bcd), 32'h8642);
        frame(codes[9], codes[7], codes[5], codes[3]);
        bus.out_ready = 1'b1;
        dwell(IDLE, BLANK, 1);
        check("t6_valid", 32'(bus.out_valid), 1);
        check("t6_bcd", 32'(bus.out_bcd), 32'h3579);
        check("t6_no_ovr", 32'(bus.overrun), 0);
        dwell(IDLE, BLANK, 1);
        check("t6_drop", 32'(bus.out_valid), 0);

        dwell(IDLE, BLANK, 2);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Captures a multiplexed, active-low 4-digit seven-segment drive (segment bus plus digit selects) and recovers the displayed BCD value. It is the inverse of the BCD-to-segment decoder and sits on the display side of the board. It lets a self-check path or a bench read back what the display is actually showing. Completed frames are presented on a valid/ready output.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical cycles required before a digit is accepted (legal range ≥1).
- CNT_W, $clog2(STABLE_CYCLES+1): width of the stability counter.

Ports:
- clk  in  1: single clock; all logic on the rising edge.
- rst  in  1: synchronous, active-high reset.
- seg  in  7: segment drive, active-low; bit6=a … bit0=g.
- an  in  4: digit select, active-low; an[0] is the least-significant digit.
- out_valid  out  1: a frame is available.
- out_ready  in  1: the consumer accepts the frame.
- out_bcd  out  16: four BCD digits; [3:0] is digit 0.
- out_blank  out  4: digit shows all segments off (seg=7'b1111111).
- out_err  out  4: digit pattern is not in the code table.
- overrun  out  1: one-cycle pulse when a completed frame is dropped.

## Operation
- Code table (seg → value):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0001100→9
  - 1111111 → blank (digit 0, blank bit set)
  - anything else → error (digit 0, err bit set)
- `an` is valid only when exactly one bit is low. All-high or multiple-low `an` is idle.
- FSM states:
  - SEARCH: wait for a valid `an`. On entry, latch `an`/`seg` and set the counter to 1, then go to COUNT.
  - COUNT: if `an` and `seg` equal the latched values, increment the counter. When the counter reaches STABLE_CYCLES, decode into the digit slot, set that slot's capture-mask bit, and go to HOLD. Any change returns to SEARCH with no capture.
  - HOLD: stay until `an` differs from the latched select, then go to SEARCH. This gives at most one capture per select dwell, and the same digit may re-capture on its next dwell.
- Recapture of a slot before the frame completes overwrites that slot; the last value wins.
- Frame completion: when the capture mask reaches 4'b1111:
  - copy the digits, blank bits and err bits to the output registers;
  - assert out_valid;
  - clear the mask.
- The output is held stable while out_valid=1 and out_ready=0.
- Transfer occurs when out_valid && out_ready. out_valid then drops the next cycle unless a new frame completes in that same cycle.
- Simultaneous completion and transfer: the new frame loads and out_valid stays 1.
- Completion while out_valid=1 and no transfer: the new frame is discarded, overrun pulses for 1 cycle, and the mask still clears.

## Timing
- Reset values:
  - out_valid=0, out_bcd=0, out_blank=0, out_err=0, overrun=0;
  - capture mask=0, FSM=SEARCH, counter=0.
- Reset mid-dwell or mid-frame discards all partial state.
- Digit acceptance: a dwell that is stable from cycle t is captured at the edge ending cycle t+STABLE_CYCLES−1. With STABLE_CYCLES=1, capture happens in the first cycle.
- Frame latency: out_valid rises 1 cycle after the fourth distinct slot is captured.
- No combinational path from inputs to outputs except that out_ready affects nothing combinationally.

## Structure
- Shared package `seg7_pkg`:
  - the 10 segment-code constants plus SEG_BLANK;
  - the FSM state enum;
  - a digit-field record (value, blank, err).
  - The same constants are to be reused by the forward decoder.
- One sub-module, `seg7_to_bcd`: a combinational 7→4 table plus blank/err flags.
- Top level: FSM, stability counter, four slot registers, mask, and output register.

## Test plan
1. Drive 3,2,1,0 stably for 4 cycles each, in order an=1110,1101,1011,0111, with seg matching "1234" (digit0=4 etc.) and out_ready=1 → out_valid=1 for one cycle, out_bcd=16'h1234, blank=0, err=0.
2. Dwell of 3 cycles on an=1110 with STABLE_CYCLES=4 → no capture. Extend it to 4 cycles → slot 0 captured.
3. an=1110, seg=1111111 and seg=1111110 on slot 1 → out_blank[0]=1 and out_err[1]=1, both with digit 0.
4. Complete two frames with out_ready=0 → the first frame is held, overrun pulses once, and out_bcd is unchanged. Raise out_ready → out_valid drops the next cycle.
5. Glitch `seg` mid-dwell, and apply an=1100 → no capture for either. Assert rst mid-frame, then send three digits → no out_valid.
6. Frame completes in the same cycle as a transfer → out_valid stays 1 with the new out_bcd.
